// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Multi-cycle RV32M multiply/divide execution unit that sits beside the ALU in
// the execute stage. One M-extension instruction is accepted at a time. The
// unit holds the upstream pipeline with `stall` while it works and then pulses
// `done` for one cycle with the result.
//
// Multiplies use shift-add over a 2*WIDTH accumulator. Divides use restoring
// division. Both work on operand magnitudes, and the sign is applied in FIX.
// Divide-by-zero, signed overflow and multiply-by-zero are resolved when the
// op is accepted and go straight to DONE.
//
// Optional build macro: MULDIV_FAST_MUL_EN
//   When defined, multiplies take a single-cycle combinational product
//   (IDLE -> FIX -> DONE). Divides still iterate through CALC.
//
// Parameters:
//   WIDTH   operand/result width (even, >= 8)
//   UNROLL  bits retired per CALC cycle (1, 2 or 4; must divide WIDTH)
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid            execute stage presents an instruction this cycle
//   ALUOp/Funct7/Funct3 decode fields; M op = ALUOp 2'b10 with Funct7 7'b0000001
//   flush               aborts any operation in progress
//   op_a, op_b          rs1 / rs2 values
//   stall               hold upstream pipeline
//   busy                unit not idle
//   done                one-cycle result-valid pulse
//   result              last result, held until the next accepted op completes
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int STEPS = WIDTH / UNROLL;
  localparam int CNT_W = $clog2(STEPS + 1);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STEPS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             op_q, op_d;
  logic                   sa_q, sa_d;
  logic                   sb_q, sb_d;
  logic [WIDTH-1:0]       mag_a_q, mag_a_d;
  logic [WIDTH-1:0]       mag_b_q, mag_b_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       result_q, result_d;

  logic                   is_m_s;
  logic                   accept_s;
  logic                   in_sa_s;
  logic                   in_sb_s;
  logic [WIDTH-1:0]       in_mag_a_s;
  logic [WIDTH-1:0]       in_mag_b_s;
  logic                   div_zero_s;
  logic                   ovf_s;
  logic                   mul_zero_s;
  logic                   special_s;
  logic [WIDTH-1:0]       special_res_s;

  logic [2*WIDTH-1:0]     step_acc_s;
  logic [WIDTH:0]         div_rem_s;
  logic [WIDTH-1:0]       div_quo_s;
  logic [WIDTH:0]         mul_sum_s;

  logic [2*WIDTH-1:0]     prod_s;
  logic [2*WIDTH-1:0]     prod_fix_s;
  logic                   neg_s;
  logic [WIDTH-1:0]       quo_s;
  logic [WIDTH-1:0]       rem_s;
  logic [WIDTH-1:0]       fix_res_s;

  // Decode the instruction, then form operand signs, magnitudes and special cases.
  always_comb begin
    is_m_s   = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
    accept_s = in_valid && is_m_s && (state_q == S_IDLE) && !flush;

    // MUL keeps unsigned magnitudes, because its low word does not depend on sign.
    case (Funct3)
      OP_MULH, OP_DIV, OP_REM: begin
        in_sa_s = op_a[WIDTH-1];
        in_sb_s = op_b[WIDTH-1];
      end
      OP_MULHSU: begin
        in_sa_s = op_a[WIDTH-1];
        in_sb_s = 1'b0;
      end
      default: begin
        in_sa_s = 1'b0;
        in_sb_s = 1'b0;
      end
    endcase

    in_mag_a_s = in_sa_s ? -op_a : op_a;
    in_mag_b_s = in_sb_s ? -op_b : op_b;

    div_zero_s = Funct3[2] && (op_b == {WIDTH{1'b0}});
    ovf_s      = ((Funct3 == OP_DIV) || (Funct3 == OP_REM)) &&
                 (op_a == MOST_NEG) && (op_b == ALL_ONES);
    mul_zero_s = !Funct3[2] && ((op_a == {WIDTH{1'b0}}) || (op_b == {WIDTH{1'b0}}));
    special_s  = div_zero_s || ovf_s || mul_zero_s;

    // Funct3[1] separates REM/REMU from DIV/DIVU among the divide ops.
    if (div_zero_s) begin
      special_res_s = Funct3[1] ? op_a : ALL_ONES;
    end else if (ovf_s) begin
      special_res_s = Funct3[1] ? {WIDTH{1'b0}} : op_a;
    end else begin
      special_res_s = {WIDTH{1'b0}};
    end
  end

  // Retire UNROLL bits of the multiply or divide in one CALC cycle.
  always_comb begin
    step_acc_s = acc_q;
    div_rem_s  = {(WIDTH+1){1'b0}};
    div_quo_s  = {WIDTH{1'b0}};
    mul_sum_s  = {(WIDTH+1){1'b0}};
    for (int u = 0; u < UNROLL; u++) begin
      if (op_q[2]) begin
        // Restoring divide: {partial remainder, next dividend bit} vs divisor.
        div_rem_s = step_acc_s[2*WIDTH-1:WIDTH-1];
        div_quo_s = {step_acc_s[WIDTH-2:0], 1'b0};
        if (div_rem_s >= {1'b0, mag_b_q}) begin
          div_rem_s    = div_rem_s - {1'b0, mag_b_q};
          div_quo_s[0] = 1'b1;
        end else begin
          div_quo_s[0] = 1'b0;
        end
        step_acc_s = {div_rem_s[WIDTH-1:0], div_quo_s};
      end else begin
        // Shift-add multiply: the carry out of the add shifts back into the top.
        if (step_acc_s[0]) begin
          mul_sum_s = {1'b0, step_acc_s[2*WIDTH-1:WIDTH]} + {1'b0, mag_a_q};
        end else begin
          mul_sum_s = {1'b0, step_acc_s[2*WIDTH-1:WIDTH]};
        end
        step_acc_s = {mul_sum_s, step_acc_s[WIDTH-1:1]};
      end
    end
  end

  // Apply the result sign and select the word the op returns.
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    if (op_q[2]) begin
      prod_s = acc_q;
    end else begin
      prod_s = {{WIDTH{1'b0}}, mag_a_q} * {{WIDTH{1'b0}}, mag_b_q};
    end
`else
    prod_s = acc_q;
`endif
    neg_s      = sa_q ^ sb_q;
    prod_fix_s = neg_s ? -prod_s : prod_s;
    quo_s      = acc_q[WIDTH-1:0];
    rem_s      = acc_q[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MUL:                       fix_res_s = prod_fix_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prod_fix_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fix_res_s = neg_s ? -quo_s : quo_s;
      OP_REM, OP_REMU:              fix_res_s = sa_q ? -rem_s : rem_s;
      default:                      fix_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Next-state logic; flush overrides everything, including an accept or CALC->FIX.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            op_d    = Funct3;
            sa_d    = in_sa_s;
            sb_d    = in_sb_s;
            mag_a_d = in_mag_a_s;
            mag_b_d = in_mag_b_s;
            // A divide shifts the dividend out of the low half.
            // A multiply shifts the multiplier out of the low half.
            acc_d   = Funct3[2] ? {{WIDTH{1'b0}}, in_mag_a_s} : {{WIDTH{1'b0}}, in_mag_b_s};
            if (special_s) begin
              state_d  = S_DONE;
              cnt_d    = {CNT_W{1'b0}};
              result_d = special_res_s;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!Funct3[2]) begin
              state_d = S_FIX;
              cnt_d   = {CNT_W{1'b0}};
`endif
            end else begin
              state_d = S_CALC;
              cnt_d   = CNT_INIT;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CALC: begin
          acc_d = step_acc_s;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_FIX;
          end else begin
            state_d = S_CALC;
          end
        end
        S_FIX: begin
          result_d = fix_res_s;
          state_d  = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      op_q     <= 3'b000;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      mag_a_q  <= {WIDTH{1'b0}};
      mag_b_q  <= {WIDTH{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      result_q <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // Stall drops in the DONE cycle, because the instruction retires there.
  assign stall  = accept_s || (state_q == S_CALC) || (state_q == S_FIX);
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  alu_op = 2'b00;
  logic [6:0]  funct7 = 7'b0000000;
  logic [2:0]  funct3 = 3'b000;
  logic        flush = 1'b0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        stall, busy, done;
  logic [31:0] result;

  logic        h_in_valid = 1'b0;
  logic [1:0]  h_alu_op = 2'b10;
  logic [6:0]  h_funct7 = 7'b0000001;
  logic [2:0]  h_funct3 = 3'b000;
  logic        h_flush = 1'b0;
  logic [15:0] h_a = 16'd0;
  logic [15:0] h_b = 16'd0;
  logic        h_stall, h_busy, h_done;
  logic [15:0] h_result;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  muldiv_unit #(.WIDTH(32), .UNROLL(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ALUOp(alu_op), .Funct7(funct7),
    .Funct3(funct3), .flush(flush), .op_a(op_a), .op_b(op_b),
    .stall(stall), .busy(busy), .done(done), .result(result)
  );

  muldiv_unit #(.WIDTH(16), .UNROLL(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .ALUOp(h_alu_op), .Funct7(h_funct7),
    .Funct3(h_funct3), .flush(h_flush), .op_a(h_a), .op_b(h_b),
    .stall(h_stall), .busy(h_busy), .done(h_done), .result(h_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result from RISC-V M semantics using 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = 32'd0;
    case (f)
      3'b000: begin up = ua * ub; r = up[31:0]; end
      3'b001: begin p = sa * sb; r = p[63:32]; end
      3'b010: begin p = sa * longint'(ub); r = p[63:32]; end
      3'b011: begin up = ua * ub; r = up[63:32]; end
      3'b100: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'b101: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else begin up = ua / ub; r = up[31:0]; end
      end
      3'b110: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 32'd0) r = a;
        else begin up = ua % ub; r = up[31:0]; end
      end
    endcase
    return r;
  endfunction

  // Cycles from accept to the done pulse.
  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1;
    if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (!f[2] && (a == 32'd0 || b == 32'd0)) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 2;
`endif
    return 34;
  endfunction

  // Cycle-by-cycle comparison of the 32-bit unit against the transaction model.
  logic        m_inflight = 1'b0;
  int          m_acc = 0;
  int          m_done = 0;
  logic [31:0] m_res = 32'd0;
  logic [31:0] m_last = 32'd0;

  initial begin : compare
    logic is_m, acc_now, e_busy, e_done, e_stall;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_inflight = 1'b0;
        m_last     = 32'd0;
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_stall", stall, 1'b0);
        chk_bit("rst_done", done, 1'b0);
        chk_word("rst_result", result, 32'd0);
      end else begin
        is_m    = (alu_op == 2'b10) && (funct7 == 7'b0000001);
        acc_now = in_valid && is_m && !flush && !m_inflight;
        e_busy  = m_inflight;
        e_done  = m_inflight && (cyc == m_done);
        e_stall = acc_now || (m_inflight && cyc < m_done);
        if (e_done) m_last = m_res;
        chk_bit("busy", busy, e_busy);
        chk_bit("stall", stall, e_stall);
        chk_bit("done", done, e_done);
        chk_word("result", result, m_last);
        if (e_done || flush || (m_inflight && cyc > m_done)) m_inflight = 1'b0;
        if (acc_now) begin
          m_inflight = 1'b1;
          m_acc      = cyc;
          m_done     = cyc + ref_latency(funct3, op_a, op_b);
          m_res      = ref_result(funct3, op_a, op_b);
        end
      end
    end
  end

  // Issue one M op and follow it until done, flush or a timeout.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit pokes, input int flush_at,
                        output logic [31:0] res, output int lat, output bit seen, output bit ended);
    int start;
    @(posedge clk); #1;
    in_valid = 1'b1; alu_op = 2'b10; funct7 = 7'b0000001; funct3 = f;
    op_a = a; op_b = b; flush = 1'b0;
    start = cyc;
    seen = 1'b0; ended = 1'b0; lat = -1; res = 32'd0;
    for (int k = 1; k <= 60 && !ended; k++) begin
      @(posedge clk); #1;
      flush    = (k == flush_at);
      in_valid = pokes && (k != flush_at) && ($urandom_range(0, 3) == 0);
      alu_op   = 2'($urandom);
      funct7   = ($urandom_range(0, 1) == 1) ? 7'b0000001 : 7'($urandom);
      funct3   = 3'($urandom);
      op_a     = $urandom;
      op_b     = $urandom;
      @(negedge clk);
      if (done) begin
        seen = 1'b1; ended = 1'b1; lat = cyc - start; res = result;
      end else if (flush) begin
        ended = 1'b1;
      end else begin
        ended = 1'b0;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic directed(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res; int lat; bit seen, ended;
    run_op(f, a, b, 1'b0, 0, res, lat, seen, ended);
    chk_int({name, "_lat"}, lat, exp_lat);
    chk_word({name, "_res"}, res, exp_res);
  endtask

  task automatic run16(input string name, input logic [2:0] f, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp_res, input int exp_lat);
    int start; int lat; logic [15:0] res;
    @(posedge clk); #1;
    h_in_valid = 1'b1; h_funct3 = f; h_a = a; h_b = b;
    start = cyc; lat = -1; res = 16'd0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      h_in_valid = 1'b0;
      @(negedge clk);
      if (h_done) begin
        lat = cyc - start; res = h_result;
      end else begin
        chk_bit({name, "_stall"}, h_stall, 1'b1);
      end
    end
    chk_int({name, "_lat"}, lat, exp_lat);
    chk_word({name, "_res"}, {16'd0, res}, {16'd0, exp_res});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 15));
      5: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin : driver
    logic [31:0] res; int lat; bit seen, ended; int mul_lat; int start; int flush_at;
`ifdef MULDIV_FAST_MUL_EN
    mul_lat = 2;
`else
    mul_lat = 34;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk_bit("init_busy", busy, 1'b0);
    chk_word("init_result", result, 32'd0);
    rst_n = 1'b1;

    directed("remu_7_2_pre", 3'b111, 32'd7, 32'd2, 32'd1, 34);

    // Asynchronous reset in the middle of a DIVU
    @(posedge clk); #1;
    in_valid = 1'b1; alu_op = 2'b10; funct7 = 7'b0000001; funct3 = 3'b101;
    op_a = 32'd100; op_b = 32'd7;
    start = cyc;
    while (cyc < start + 10) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    chk_bit("midcalc_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_bit("reset_busy", busy, 1'b0);
    chk_bit("reset_stall", stall, 1'b0);
    chk_word("reset_result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    directed("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 34);
    directed("mul", 3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, mul_lat);
    directed("mulh", 3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, mul_lat);
    directed("mulhsu", 3'b010, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, mul_lat);
    directed("mulhu", 3'b011, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, mul_lat);
    directed("div_m7_2", 3'b100, -32'd7, 32'd2, 32'hFFFF_FFFD, 34);
    directed("rem_m7_2", 3'b110, -32'd7, 32'd2, 32'hFFFF_FFFF, 34);
    directed("remu_7_2", 3'b111, 32'd7, 32'd2, 32'd1, 34);
    directed("div_5_0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    directed("remu_5_0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
    directed("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    directed("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    directed("mul_zero", 3'b001, 32'd0, 32'h1234_5678, 32'd0, 1);
    directed("remu_7_2_b", 3'b111, 32'd7, 32'd2, 32'd1, 34);

    // Flush at cycle 5 of a DIV
    run_op(3'b100, 32'd1000, 32'd3, 1'b0, 5, res, lat, seen, ended);
    chk_bit("flush_nodone", seen, 1'b0);
    chk_bit("flush_busy", busy, 1'b0);
    chk_word("flush_hold", result, 32'd1);

    // Non-M instruction (ADD) is ignored
    @(posedge clk); #1;
    in_valid = 1'b1; alu_op = 2'b10; funct7 = 7'b0000000; funct3 = 3'b000;
    op_a = 32'd9; op_b = 32'd4;
    #1;
    chk_bit("add_stall", stall, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_bit("add_busy", busy, 1'b0);
    chk_word("add_result", result, 32'd1);

    // Randomised traffic with busy-time pokes and occasional flushes
    for (int i = 0; i < 200; i++) begin
      flush_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 20) : 0;
      run_op(3'($urandom), pick(), pick(), 1'b1, flush_at, res, lat, seen, ended);
      chk_bit("no_timeout", ended, 1'b1);
    end

    run16("h_divu", 3'b101, 16'hFFFF, 16'h00FF, 16'h0101, 10);
    run16("h_div", 3'b100, 16'hFFF9, 16'h0002, 16'hFFFD, 10);
    run16("h_rem", 3'b110, 16'hFFF9, 16'h0002, 16'hFFFF, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
